// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int PIX_W  = 8;
    localparam int EDGE_W = 16;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/sobel_raster_cnt.sv
// Raster-order row/column counter with a linear index and a last-pixel flag.
module sobel_raster_cnt
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int ROW_W  = $clog2(IMG_H),
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              step,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(frame_pixels(IMG_W, IMG_H) - 1);

    assign last = (idx == IDX_MAX);

    // The linear index runs alongside row/col so no multiplier is needed for addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (step) begin
            idx <= idx + 1'b1;
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: raster-reads a source frame into the Sobel window and
// writes the interior edge map to the result RAM while counting edges.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [EDGE_W-1:0] thr_in,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [PIX_W-1:0]  src_rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              win_clr,
    output logic [EDGE_W-1:0] thr_cfg,
    input  logic              edge_bin,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic              res_wr_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  edge_count
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    state_t            state;
    logic              drain_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [ROW_W-1:0]  rd_row, s1_row, s2_row;
    logic [COL_W-1:0]  rd_col, s1_col, s2_col;
    logic [ADDR_W-1:0] rd_idx, s1_idx, s2_addr;
    logic              rd_last, s1_valid, s2_valid;
    logic              accept, kill, cnt_step;

    assign accept   = (state == IDLE) && start;
    assign kill     = (state != IDLE) && abort;
    assign cnt_step = (state == FETCH) && !kill;

    sobel_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_issue_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .step (cnt_step),
        .row  (rd_row),
        .col  (rd_col),
        .idx  (rd_idx),
        .last (rd_last)
    );

    assign src_rd_addr = rd_idx;

    // Two drain cycles let the final read reach the write stage before DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_rd_en  <= 1'b0;
            win_clr    <= 1'b0;
            thr_cfg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drain_cnt  <= 1'b0;
            edge_count <= '0;
        end else begin
            win_clr <= 1'b0;
            done    <= 1'b0;
            if (kill) begin
                state     <= IDLE;
                src_rd_en <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= FETCH;
                            src_rd_en <= 1'b1;
                            busy      <= 1'b1;
                            win_clr   <= 1'b1;
                            thr_cfg   <= thr_in;
                        end
                    end
                    FETCH: begin
                        if (rd_last) begin
                            state     <= DRAIN;
                            src_rd_en <= 1'b0;
                            drain_cnt <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt) state <= DONE;
                        else           drain_cnt <= 1'b1;
                    end
                    DONE: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        edge_count <= run_cnt;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The read coordinate travels with its valid so the write side never recounts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_idx   <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_addr  <= '0;
            run_cnt  <= '0;
        end else begin
            s1_valid <= src_rd_en && !kill;
            s2_valid <= s1_valid && !kill;
            s1_row   <= rd_row;
            s1_col   <= rd_col;
            s1_idx   <= rd_idx;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
            if (s1_valid) s2_addr <= s1_idx - CENTRE_OFS;
            if (accept)
                run_cnt <= '0;
            else if (res_wr_en && edge_bin && (run_cnt != CNT_MAX))
                run_cnt <= run_cnt + 1'b1;
        end
    end

    assign pix_valid = s1_valid;
    assign pix_out   = src_rd_data;

    // Windows whose bottom-right sits in row/col 0 or 1 straddle a border or a row wrap.
    assign res_wr_en   = s2_valid && (s2_row >= ROW_W'(2)) && (s2_col >= COL_W'(2));
    assign res_wr_addr = s2_addr;
    assign res_wr_data = edge_bin;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: source RAM and window/threshold models around the
// DUT, with expected result writes queued per frame and popped as writes appear.
module tb_sobel_frame_ctrl;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int AW  = 12;
    localparam int CW  = 4;
    localparam int N   = W * H;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [15:0]   thr_in;
    logic          src_rd_en;
    logic [AW-1:0] src_rd_addr;
    logic [7:0]    src_rd_data = 8'h00;
    logic [7:0]    pix_out;
    logic          pix_valid;
    logic          win_clr;
    logic [15:0]   thr_cfg;
    logic          edge_bin = 1'b0;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic          res_wr_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] edge_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_rd = 0;
    int   first_rd_cyc = 0;
    int   last_rd_cyc = 0;
    int   exp_cnt = 0;
    int   wcount = 0;
    wr_t  exp_q[$];
    logic [7:0] img [N];
    logic [7:0] win_img [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sobel_frame_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .thr_in     (thr_in),
        .src_rd_en  (src_rd_en),
        .src_rd_addr(src_rd_addr),
        .src_rd_data(src_rd_data),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .win_clr    (win_clr),
        .thr_cfg    (thr_cfg),
        .edge_bin   (edge_bin),
        .res_wr_en  (res_wr_en),
        .res_wr_addr(res_wr_addr),
        .res_wr_data(res_wr_data),
        .busy       (busy),
        .done       (done),
        .edge_count (edge_count)
    );

    function automatic logic sobel_ref(input logic [7:0] a [N], input int r, input int c,
                                       input logic [15:0] thr);
        int p [3][3];
        int gx;
        int gy;
        if (r < 1 || c < 1 || r > H - 2 || c > W - 2) return 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(a[(r - 1 + i) * W + (c - 1 + j)]);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > int'(thr);
    endfunction

    function automatic logic window_edge(input int k, input logic [7:0] px);
        logic [7:0] t [N];
        t    = win_img;
        t[k] = px;
        return sobel_ref(t, k / W - 1, k % W - 1, thr_cfg);
    endfunction

    always @(posedge clk) begin
        if (src_rd_en && int'(src_rd_addr) < N) src_rd_data <= img[int'(src_rd_addr)];
    end

    // Window model: edge_bin follows the window whose bottom-right is the newest pixel.
    always @(posedge clk) begin
        if (win_clr) begin
            wcount <= 0;
        end else if (pix_valid && wcount < N) begin
            win_img[wcount] <= pix_out;
            edge_bin        <= window_edge(wcount, pix_out);
            wcount          <= wcount + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (src_rd_en) begin
                    if (exp_rd == 0) first_rd_cyc = cyc;
                    last_rd_cyc = cyc;
                    check_output("rd_addr", 32'(src_rd_addr), exp_rd);
                    exp_rd++;
                end
                if (res_wr_en) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("[TB] FAIL wr_unexpected observed addr=%0d expected no write", res_wr_addr);
                    end
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check_output("wr_addr", 32'(res_wr_addr), 32'(w.addr));
                        check_output("wr_data", 32'(res_wr_data), 32'(w.data));
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [15:0] thr);
        wr_t w;
        int  ones;
        ones = 0;
        @(negedge clk);
        exp_q.delete();
        exp_rd = 0;
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                w.addr = AW'(r * W + c);
                w.data = sobel_ref(img, r, c, thr);
                if (w.data) ones++;
                exp_q.push_back(w);
            end
        end
        exp_cnt   = (ones > SAT) ? SAT : ones;
        start     = 1'b1;
        thr_in    = thr;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check_output("win_clr_pulse", 32'(win_clr), 1);
        check_output("busy_start", 32'(busy), 1);
    endtask

    task automatic check_frame(input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < N + 40; i++) begin
            if (done) begin
                lat = cyc - start_cyc;
                break;
            end
            @(negedge clk);
        end
        check_output({tag, "_latency"}, lat, N + 4);
        check_output({tag, "_edge_count"}, 32'(edge_count), exp_cnt);
        check_output({tag, "_busy_at_done"}, 32'(busy), 0);
        check_output({tag, "_writes_left"}, exp_q.size(), 0);
        check_output({tag, "_reads"}, exp_rd, N);
        check_output({tag, "_read_span"}, last_rd_cyc - first_rd_cyc, N - 1);
        @(negedge clk);
        check_output({tag, "_done_one_cycle"}, 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int prev_cnt;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        thr_in = 16'd0;
        for (int i = 0; i < N; i++) img[i] = 8'h00;
        repeat (3) @(negedge clk);

        check_output("rst_rd_en", 32'(src_rd_en), 0);
        check_output("rst_rd_addr", 32'(src_rd_addr), 0);
        check_output("rst_wr_en", 32'(res_wr_en), 0);
        check_output("rst_wr_addr", 32'(res_wr_addr), 0);
        check_output("rst_thr_cfg", 32'(thr_cfg), 0);
        check_output("rst_edge_count", 32'(edge_count), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_pix_valid", 32'(pix_valid), 0);
        check_output("rst_win_clr", 32'(win_clr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] flat frame");
        for (int i = 0; i < N; i++) img[i] = 8'h40;
        apply_stimulus(16'd100);
        check_output("flat_thr_cfg", 32'(thr_cfg), 100);
        check_frame("flat");

        $display("[TB] vertical step frame");
        for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 8'h00 : 8'hff;
        apply_stimulus(16'd100);
        check_frame("step");
        check_output("step_count_12", 32'(edge_count), 12);

        $display("[TB] wrapped ramp frame");
        for (int i = 0; i < N; i++) img[i] = 8'((i / W) * 37 + (i % W) * 23);
        apply_stimulus(16'd200);
        check_frame("ramp");

        $display("[TB] stripe frame with start and threshold change mid-frame");
        for (int i = 0; i < N; i++) img[i] = ((i % 4) < 2) ? 8'h00 : 8'hff;
        apply_stimulus(16'd100);
        repeat (10) @(negedge clk);
        start  = 1'b1;
        thr_in = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_thr_cfg_held", 32'(thr_cfg), 100);
        check_frame("stripe");
        check_output("stripe_saturated", 32'(edge_count), SAT);

        $display("[TB] abort on third read");
        prev_cnt = SAT;
        for (int i = 0; i < N; i++) img[i] = ((i % W) < 4) ? 8'h00 : 8'hff;
        apply_stimulus(16'd100);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_rd_en", 32'(src_rd_en), 0);
        check_output("abort_busy", 32'(busy), 0);
        check_output("abort_pix_valid", 32'(pix_valid), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_output("abort_no_done", 32'(done), 0);
        end
        check_output("abort_reads", exp_rd, 3);
        check_output("abort_count_kept", 32'(edge_count), prev_cnt);
        apply_stimulus(16'd100);
        check_frame("restart");

        $display("[TB] reset during fetch");
        apply_stimulus(16'd100);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_output("midrst_rd_en", 32'(src_rd_en), 0);
        check_output("midrst_rd_addr", 32'(src_rd_addr), 0);
        check_output("midrst_busy", 32'(busy), 0);
        check_output("midrst_pix_valid", 32'(pix_valid), 0);
        check_output("midrst_wr_en", 32'(res_wr_en), 0);
        check_output("midrst_thr_cfg", 32'(thr_cfg), 0);
        check_output("midrst_edge_count", 32'(edge_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("post_rst_rd_en", 32'(src_rd_en), 0);
            check_output("post_rst_busy", 32'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Frame-level sequencer for the Sobel edge pipeline (line-buffer window, Sobel core, threshold).
- On a start pulse it raster-reads one IMG_W x IMG_H 8-bit frame from a synchronous source RAM and streams the pixels into the window.
- It masks border results and writes the interior binary edge map to a result RAM.
- It counts edge pixels and reports busy/done, replacing the free-running switch-fed stream used on the board today.

Parameters:
- IMG_W, 64, frame width in pixels (>=3)
- IMG_H, 64, frame height in pixels (>=3)
- ADDR_W, 12, source/result address width; must hold IMG_W*IMG_H-1
- CNT_W, 12, edge-count width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start request
- abort  in  1  one-cycle abort request
- thr_in  in  16  edge threshold, sampled on accepted start
- src_rd_en  out  1  source RAM read strobe
- src_rd_addr  out  ADDR_W  source read address
- src_rd_data  in  8  source data, valid 1 cycle after src_rd_en
- pix_out  out  8  pixel to window (= src_rd_data)
- pix_valid  out  1  pixel strobe to window
- win_clr  out  1  one-cycle window/line-buffer clear
- thr_cfg  out  16  latched threshold to threshold block
- edge_bin  in  1  threshold result for current window (combinational from window registers)
- res_wr_en  out  1  result RAM write strobe
- res_wr_addr  out  ADDR_W  result write address
- res_wr_data  out  1  binary edge value
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- edge_count  out  CNT_W  edges in last completed frame (saturating)

Behaviour:
- Reset (rst_n low, async): state IDLE, all strobes 0, src_rd_addr 0, res_wr_addr 0, thr_cfg 0, edge_count 0, busy 0, done 0.
- States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE, start=1:
  - Latch thr_cfg<=thr_in.
  - Clear row/col counters and the running edge counter.
  - Pulse win_clr for 1 cycle; go to FETCH next cycle.
- start while busy: ignored.
- FETCH:
  - src_rd_en=1 every cycle; src_rd_addr=row*IMG_W+col, raster order.
  - col wraps IMG_W-1->0 with row+1.
  - After issuing (IMG_H-1, IMG_W-1), go to DRAIN.
  - Exactly IMG_W*IMG_H reads, no gaps.
- Pipeline (read issued at cycle t for (r,c)):
  - t+1: pix_valid=1, pix_out=src_rd_data. pix_valid is src_rd_en delayed one register; the coordinate is carried alongside.
  - t+2: window holds (r,c) as bottom-right tap; edge_bin refers to centre (r-1,c-1).
  - Stage-2 valid and coordinate are registered.
  - res_wr_en = stage2_valid & r>=2 & c>=2. This suppresses row-wrap-corrupted and partial windows.
  - res_wr_addr=(r-1)*IMG_W+(c-1); res_wr_data=edge_bin.
- Output extent: only the (IMG_W-2)x(IMG_H-2) interior is written; border locations are untouched.
- Edge counter: +1 per write with edge_bin=1; saturates at 2^CNT_W-1.
- DRAIN: exactly 2 cycles, so the last write (centre IMG_H-2, IMG_W-2) issues; then DONE.
- DONE: done=1 for one cycle; edge_count<=running count; return to IDLE.
- busy: 1 in FETCH, DRAIN and DONE.
- abort (any non-IDLE state):
  - Next state IDLE; pipeline valids squashed; no further writes.
  - done not pulsed; edge_count keeps its previous value.
  - abort and start in the same cycle from IDLE: start wins, abort ignored.
- Throughput: 1 pixel/cycle. Frame latency from start to done pulse = IMG_W*IMG_H + 4 cycles.

Decomposition:
- Package sobel_pkg: state enum (IDLE, FETCH, DRAIN, DONE); PIX_W=8; EDGE_W=16; localparam helpers for frame size.
- Sub-module sobel_raster_cnt: row/col counter with wrap and last flag. Instantiated once for the issue side; the coordinate is pipelined, not recounted.

Test Plan:
- Reset mid-FETCH: rst_n low at cycle 10 -> all outputs zero immediately; no writes after release until a new start.
- 4x4 flat frame (all 0x40), thr 100: 16 reads, addr 0..15 -> 4 writes at addr 5,6,9,10, data 0; done at cycle 20 after start; edge_count=0.
- 8x8 vertical step (cols 0-3 = 0, cols 4-7 = 255), thr 100: writes flag cols 3,4 on rows 1-6; edge_count=12.
- Column-wrap masking on 5x5 ramp: no res_wr_en when stage coordinate c<2 or r<2; exactly 9 writes.
- Abort at 3rd read of 8x8: no done; no writes after 2 cycles; edge_count keeps prior value; immediate restart completes normally.
- start during busy: ignored, read sequence unperturbed; thr_in change mid-frame leaves thr_cfg unchanged; saturation check with CNT_W=3 on all-edge frame -> edge_count=7.
